// File: rtl/sha256_pkg.sv
// Shared types, constants and round functions for the streaming SHA-256 core.
// The SHA-224 option of the top level is controlled by SHA256_STREAM_SHA224_EN.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Working variables a..h, a in the most significant word.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] SHA256_IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [255:0] SHA224_IV = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round.
module sha256_round
    import sha256_pkg::*;
(
    input  work_t       st_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output work_t       st_o
);

    logic [31:0] t1;
    logic [31:0] t2;

    // Round function: shift the working variables and fold in T1/T2.
    always_comb begin
        t1   = st_i.h + bsig1(st_i.e) + ch(st_i.e, st_i.f, st_i.g) + k_i + w_i;
        t2   = bsig0(st_i.a) + maj(st_i.a, st_i.b, st_i.c);
        st_o = '{a: t1 + t2, b: st_i.a, c: st_i.b, d: st_i.c,
                 e: st_i.d + t1, f: st_i.e, g: st_i.f, h: st_i.g};
    end

endmodule

// File: rtl/sha256_stream.sv
// Streaming SHA-256 core: multi-block chaining, valid/ready handshakes and
// ROUNDS_PER_CYCLE rounds per clock. Define SHA256_STREAM_SHA224_EN to add
// the mode224 input and SHA-224 output truncation.
module sha256_stream
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
`ifdef SHA256_STREAM_SHA224_EN
    input  logic         mode224,
`endif
    input  logic [511:0] M_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] H_out
);

    localparam int unsigned R            = ROUNDS_PER_CYCLE;
    localparam int unsigned ROUND_CYCLES = 64 / R;
    localparam logic [6:0]  CNT_END      = 7'(ROUND_CYCLES * R);

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
        $fatal(1, "sha256_stream: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    state_e       state_q, state_d;
    logic         in_ready_q, in_ready_d;
    logic         out_valid_q, out_valid_d;
    logic [255:0] h_out_q, h_out_d;
    logic [255:0] chain_q, chain_d;
    logic         chain_valid_q, chain_valid_d;
    logic         last_q, last_d;
    logic [6:0]   cnt_q, cnt_d;
    work_t        st_q, st_d;
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
`ifdef SHA256_STREAM_SHA224_EN
    logic         mode_q, mode_d;
`endif

    logic [31:0]  ext [16 + R];
    logic [31:0]  k_sel [R];
    logic [255:0] iv_sel;
    logic [255:0] base_h;
    logic [255:0] sum_h;
    logic         use_iv;

    // Schedule window extended by R freshly computed words.
    always_comb begin
        for (int unsigned j = 0; j < 16; j++) ext[j] = w_q[j];
        for (int unsigned i = 0; i < R; i++)
            ext[16 + i] = ssig1(ext[14 + i]) + ext[9 + i] + ssig0(ext[1 + i]) + ext[i];
    end

    // Round constants for the rounds performed this cycle.
    always_comb begin
        for (int unsigned i = 0; i < R; i++) k_sel[i] = K[6'(cnt_q + 7'(i))];
    end

    for (genvar i = 0; i < int'(R); i++) begin : g_rnd
        work_t st_in;
        work_t st_out;
        if (i == 0) begin : g_head
            assign st_in = st_q;
        end else begin : g_link
            assign st_in = g_rnd[i-1].st_out;
        end
        sha256_round u_round (
            .st_i (st_in),
            .w_i  (ext[i]),
            .k_i  (k_sel[i]),
            .st_o (st_out)
        );
    end

    // Next-state and registered-output logic for the block FSM.
    always_comb begin
        state_d       = state_q;
        in_ready_d    = in_ready_q;
        out_valid_d   = out_valid_q;
        h_out_d       = h_out_q;
        chain_d       = chain_q;
        chain_valid_d = chain_valid_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        st_d          = st_q;
        w_d           = w_q;
`ifdef SHA256_STREAM_SHA224_EN
        mode_d        = mode_q;
        iv_sel        = mode224 ? SHA224_IV : SHA256_IV;
`else
        iv_sel        = SHA256_IV;
`endif
        use_iv        = in_first || !chain_valid_q;
        base_h        = use_iv ? iv_sel : chain_q;
        for (int unsigned j = 0; j < 8; j++)
            sum_h[255 - 32*j -: 32] = chain_q[255 - 32*j -: 32] + st_q[255 - 32*j -: 32];

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    for (int unsigned j = 0; j < 16; j++) w_d[j] = M_in[511 - 32*j -: 32];
                    last_d     = in_last;
                    chain_d    = base_h;
                    st_d       = work_t'(base_h);
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_ROUND;
`ifdef SHA256_STREAM_SHA224_EN
                    if (use_iv) mode_d = mode224;
`endif
                end
            end
            ST_ROUND: begin
                if (cnt_q == CNT_END) begin
                    state_d = ST_FINAL;
                end else begin
                    st_d  = g_rnd[R-1].st_out;
                    for (int unsigned j = 0; j < 16; j++) w_d[j] = ext[j + R];
                    cnt_d = cnt_q + 7'(R);
                end
            end
            ST_FINAL: begin
                chain_d       = sum_h;
                chain_valid_d = 1'b1;
                if (last_q) begin
`ifdef SHA256_STREAM_SHA224_EN
                    h_out_d = mode_q ? {sum_h[255:32], 32'h0} : sum_h;
`else
                    h_out_d = sum_h;
`endif
                    out_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    in_ready_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d   = 1'b0;
                    chain_valid_d = 1'b0;
                    in_ready_d    = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            h_out_q       <= '0;
            chain_q       <= '0;
            chain_valid_q <= 1'b0;
            last_q        <= 1'b0;
            cnt_q         <= '0;
            st_q          <= '0;
            for (int unsigned j = 0; j < 16; j++) w_q[j] <= '0;
`ifdef SHA256_STREAM_SHA224_EN
            mode_q        <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            h_out_q       <= h_out_d;
            chain_q       <= chain_d;
            chain_valid_q <= chain_valid_d;
            last_q        <= last_d;
            cnt_q         <= cnt_d;
            st_q          <= st_d;
            w_q           <= w_d;
`ifdef SHA256_STREAM_SHA224_EN
            mode_q        <= mode_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign H_out     = h_out_q;

endmodule

// File: tb/tb_sha256_stream.sv
// Scoreboard bench for sha256_stream: four instances (R = 1, 2, 4, 8) fed
// with known vectors and random multi-block messages, checked against an
// array-based SHA-256 reference.
module tb_sha256_stream;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_2BLK = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    typedef struct packed {
        logic [255:0] dig;
        logic [1:0]   inst;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic         in_first;
    logic         in_last;
    logic         out_ready;
    logic [511:0] m_in;
    logic [255:0] h_out [4];
`ifdef SHA256_STREAM_SHA224_EN
    logic         mode224;
`endif

    exp_t         exp_q [$];
    exp_t         mon_e;
    int unsigned  total = 0;
    int unsigned  bad = 0;
    int unsigned  cyc = 0;
    int unsigned  acc_cyc = 0;
    logic [3:0]   ov_prev = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_stream #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_first  (in_first),
            .in_last   (in_last),
`ifdef SHA256_STREAM_SHA224_EN
            .mode224   (mode224),
`endif
            .M_in      (m_in),
            .out_valid (out_valid[g]),
            .out_ready (out_ready),
            .H_out     (h_out[g])
        );
    end

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Reference compression of one block from chaining value hin.
    function automatic logic [255:0] sha_block(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hin[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: latency on each out_valid rise, digest check on each handshake.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (out_valid[k] && !ov_prev[k] && !rst) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out_valid inst=%0d actual=1 required=0", k);
                end else if (cyc - acc_cyc != 64 / (1 << k) + 2) begin
                    bad++;
                    $display("FAIL latency inst=%0d actual=%0d required=%0d", k, cyc - acc_cyc, 64 / (1 << k) + 2);
                end
            end
            if (out_valid[k] && out_ready && !rst && exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk($sformatf("digest_inst%0d", k), h_out[k], mon_e.dig);
                chk("digest_inst_id", 256'(k), 256'(mon_e.inst));
            end
        end
        ov_prev = out_valid;
    end

    // Offer one block to instance k and hold it until accepted.
    task automatic send(input int k, input logic [511:0] blk, input bit f, input bit l);
        int n = 0;
        m_in = blk;
        in_first = f;
        in_last = l;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        acc_cyc = cyc;
        in_valid[k] = 1'b0;
        for (int j = 0; j < 16; j++) m_in[511 - 32*j -: 32] = $urandom();
        in_first = 1'($urandom_range(1));
        in_last = 1'($urandom_range(1));
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout inst=%0d waited=%0d required<300", k, n);
        end
    endtask

    // Wait until every expected digest has been consumed.
    task automatic drain(input bit rnd);
        int n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        out_ready = 1'b1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cycles=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] abc_blk, emp_blk, b1_blk, b2_blk, blk;
        logic [447:0] s56;
        logic [255:0] h;
        int n, k, nb;
        bit f;

        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0] = 32'h18;
        emp_blk = '0;
        emp_blk[511:480] = 32'h80000000;
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        b1_blk = {s56, 8'h80, 56'h0};
        b2_blk = {480'h0, 32'h1c0};

        rst = 1'b1;
        in_valid = '0;
        in_first = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        m_in = '0;
`ifdef SHA256_STREAM_SHA224_EN
        mode224 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("reset_in_ready", 256'(in_ready[i]), 256'(1));
            chk("reset_out_valid", 256'(out_valid[i]), 256'(0));
            chk("reset_h_out", h_out[i], 256'(0));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // "abc" through every rounds-per-cycle variant.
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back('{dig: DIG_ABC, inst: 2'(i)});
            send(i, abc_blk, 1'b1, 1'b1);
            drain(1'b0);
        end

        // Two-block message; in_ready returns with the same latency as a digest.
        send(0, b1_blk, 1'b1, 1'b0);
        n = 0;
        while (!in_ready[0] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        chk("nonlast_ready_latency", 256'(cyc - acc_cyc), 256'(66));
        exp_q.push_back('{dig: DIG_2BLK, inst: 2'd0});
        send(0, b2_blk, 1'b0, 1'b1);
        drain(1'b0);

        // Empty message held in DONE with in_valid hammering.
        out_ready = 1'b0;
        exp_q.push_back('{dig: DIG_EMPTY, inst: 2'd0});
        send(0, emp_blk, 1'b1, 1'b1);
        n = 0;
        while (!out_valid[0] && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            in_valid[0] = 1'b1;
            for (int j = 0; j < 16; j++) m_in[511 - 32*j -: 32] = $urandom();
            chk("hold_h_out", h_out[0], DIG_EMPTY);
            chk("hold_out_valid", 256'(out_valid[0]), 256'(1));
            chk("hold_in_ready", 256'(in_ready[0]), 256'(0));
            @(posedge clk); #1;
        end
        in_valid[0] = 1'b0;
        drain(1'b0);

        // Reset mid-round, then a first=0 message must start from the IV.
        send(0, b1_blk, 1'b1, 1'b0);
        repeat (20) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_in_ready", 256'(in_ready[0]), 256'(1));
        chk("async_rst_out_valid", 256'(out_valid[0]), 256'(0));
        chk("async_rst_h_out", h_out[0], 256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back('{dig: DIG_ABC, inst: 2'd0});
        send(0, abc_blk, 1'b0, 1'b1);
        drain(1'b0);

        // Random multi-block messages on random instances with random back-pressure.
        for (int it = 0; it < 8; it++) begin
            k = $urandom_range(3);
            nb = $urandom_range(1, 3);
            h = IV;
            for (int b = 0; b < nb; b++) begin
                for (int j = 0; j < 16; j++) blk[511 - 32*j -: 32] = $urandom();
                f = (b == 0) ? 1'($urandom_range(1)) : ($urandom_range(3) == 0);
                if (f || b == 0) h = IV;
                h = sha_block(h, blk);
                if (b == nb - 1) exp_q.push_back('{dig: h, inst: 2'(k)});
                send(k, blk, f, b == nb - 1);
            end
            drain(1'b1);
        end

`ifdef SHA256_STREAM_SHA224_EN
        mode224 = 1'b1;
        exp_q.push_back('{dig: {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0}, inst: 2'd0});
        send(0, abc_blk, 1'b1, 1'b1);
        mode224 = 1'b0;
        drain(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
